inv_share_arbiter: RTL and testbench
====================================

// Module: inv_share_arbiter
// PURPOSE
// Shares one registered inverter datapath (y = ~a) between NREQ requesters.
// Selects one requester at a time by round-robin and captures its operand.
// Returns the inverted result tagged with the requester id after LAT cycles.
// Sits in front of the inverter block so several sources reuse one stage.
// PARAMETERS
// NREQ   4  number of requesters (>=2)
// WIDTH  8  operand/result width; WIDTH=1 is the plain single-bit inverter
// LAT    2  cycles from capture edge to result edge (>=1)
// PORTS
// clk        in   1           rising-edge clock
// rst_n      in   1           asynchronous, active-low reset
// req        in   NREQ        request per requester; held until its gnt is seen
// req_data   in   NREQ*WIDTH  operand of requester i at [i*WIDTH +: WIDTH]
// gnt        out  NREQ        one-hot, one-cycle pulse: operand of that index captured
// busy       out  1           high while a transaction occupies the datapath
// rsp_valid  out  1           one-cycle pulse: rsp_data/rsp_id are valid
// rsp_id     out  clog2(NREQ) index of the requester the result belongs to
// rsp_data   out  WIDTH       ~operand of that requester
// BEHAVIOUR
// Reset: rst_n low, at any time, forces the following immediately:
// - state=IDLE, ptr=0, cnt=0
// - gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0
// - any in-flight transaction is dropped; no rsp_valid follows reset release
// All outputs are registered.
// FSM states: IDLE, BUSY, RESP.
// IDLE or RESP, at a clock edge where |req:
// - winner = first i with req[i], scanning ptr, ptr+1, ... (mod NREQ)
// - gnt <= onehot(winner)
// - operand <= req_data[winner]
// - id <= winner
// - ptr <= (winner+1) mod NREQ
// - cnt <= LAT-1
// - busy <= 1
// - state <= BUSY
// IDLE or RESP, no req: gnt <= 0 and state <= IDLE. busy <= 0, except a RESP
//   edge that arbitrates keeps busy=1.
// BUSY:
// - gnt <= 0 (gnt is high for exactly one cycle)
// - req is ignored; no re-arbitration
// - cnt==0 -> rsp_valid <= 1, rsp_data <= ~operand, rsp_id <= id, state <= RESP
// - otherwise cnt <= cnt-1
// RESP:
// - rsp_valid <= 0 at the next edge
// - arbitration runs on that same edge, so there are no idle bubbles
// Timing:
// - result edge = LAT edges after the capture edge
// - throughput = one transaction per LAT+1 cycles under continuous requests
// rsp_data and rsp_id hold their last value after rsp_valid drops.
// Requester protocol:
// - hold req and req_data stable until gnt[i] is seen
// - drop req the cycle after gnt, unless issuing a new request
// A req that stays high after gnt is treated as a new request at the next
//   arbitration.
// Simultaneous requests are resolved only by the ptr rotation; no index has
//   fixed priority.
// ptr wraps NREQ-1 -> 0.
// Inversion is bitwise over the full WIDTH with no sign handling.
// TESTING
// Reset: assert rst_n=0 mid-BUSY -> all outputs 0 at once; after release, no rsp_valid, next grant starts from ptr=0.
// Single: req=4'b0001, data0=8'h5A, LAT=2 -> gnt=0001 for one cycle; rsp_valid 2 edges later; rsp_id=0, rsp_data=8'hA5.
// All four req high with data 11,22,44,88 (hex) -> grants 0,1,2,3 spaced LAT+1=3 cycles; rsp_data EE,DD,BB,77.
// Fairness: req1 and req3 re-asserted after each grant -> grant sequence 1,3,1,3; never the same index twice in a row.
// Late arrival: req2 raised while BUSY on index 0 -> granted on the RESP edge, exactly 3 cycles after gnt0.
// Boundaries: 8'h00->8'hFF, 8'hFF->8'h00; WIDTH=1 build: 0->1, 1->0, matching the inverter truth table.

Source files
------------

// File: rtl/inv_share_arbiter.sv
// Round-robin front end that time-shares one registered inverter stage between NREQ requesters.
// Results return LAT edges after capture, tagged with the requester index.
module inv_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_data
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [NREQ-1:0]  r_gnt;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic [WIDTH-1:0] r_operand;
  logic [IDW-1:0]   r_id;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [WIDTH-1:0] w_operand;
  logic [NREQ-1:0]  w_onehot;
  logic [IDW-1:0]   w_ptr_next;
  int               w_scan;

  // Scan ptr, ptr+1, ... with wrap; the first active request wins.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_operand = '0;
    w_scan    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= NREQ) w_scan = w_scan - NREQ;
      if (!w_found && req[w_scan]) begin
        w_found   = 1'b1;
        w_winner  = w_scan[IDW-1:0];
        w_operand = req_data[w_scan*WIDTH +: WIDTH];
      end
    end
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
    w_ptr_next = (w_winner == IDW'(NREQ-1)) ? '0 : w_winner + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_operand   <= '0;
      r_id        <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          r_rsp_valid <= 1'b0;
          if (w_found) begin
            r_gnt     <= w_onehot;
            r_operand <= w_operand;
            r_id      <= w_winner;
            r_ptr     <= w_ptr_next;
            r_cnt     <= CW'(LAT-1);
            r_busy    <= 1'b1;
            r_state   <= S_BUSY;
          end else begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_gnt <= '0;
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= ~r_operand;
            r_rsp_id    <= r_id;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_inv_share_arbiter.sv
// Directed bench for inv_share_arbiter: a vector table of single transactions plus
// hand-written reset, round-robin, fairness, late-arrival and WIDTH=1 sequences.
module tb_inv_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  logic [1:0]  q_req = '0;
  logic [1:0]  q_data = '0;
  logic [1:0]  q_gnt;
  logic        q_busy;
  logic        q_rv;
  logic [0:0]  q_id;
  logic [0:0]  q_rd;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  inv_share_arbiter #(.NREQ(4), .WIDTH(8), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  inv_share_arbiter #(.NREQ(2), .WIDTH(1), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(q_req), .req_data(q_data), .gnt(q_gnt),
    .busy(q_busy), .rsp_valid(q_rv), .rsp_id(q_id), .rsp_data(q_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  task automatic wait_gnt(input string nm, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != 4'b0) begin
        at = cyc;
        return;
      end
    end
    timeout(nm);
  endtask

  task automatic wait_rsp(input string nm, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) begin
        at = cyc;
        return;
      end
    end
    timeout(nm);
  endtask

  task automatic run_w1(input int idx, input logic d, input logic exp);
    int tg;
    int tr;
    tg = -1;
    tr = -1;
    q_req = '0;
    q_req[idx] = 1'b1;
    q_data[idx] = d;
    for (int i = 0; i < 20 && tg < 0; i++) begin
      tick();
      if (q_gnt != 2'b0) tg = cyc;
    end
    if (tg < 0) timeout("w1_gnt");
    chk("w1_gnt", 32'(q_gnt), 32'(1 << idx));
    q_req = '0;
    for (int i = 0; i < 20 && tr < 0; i++) begin
      tick();
      if (q_rv) tr = cyc;
    end
    if (tr < 0) timeout("w1_rsp");
    chk("w1_lat", 32'(tr - tg), 32'd1);
    chk("w1_id", 32'(q_id), 32'(idx));
    chk("w1_data", 32'(q_rd), 32'(exp));
    tick();
  endtask

  initial begin
    int tg;
    int tr;
    int prev;
    int nrv;
    logic [7:0] exp4[4];
    logic [3:0] fair_seq[4];

    tbl[0] = '{0, 8'h5A, 8'hA5};
    tbl[1] = '{1, 8'h00, 8'hFF};
    tbl[2] = '{2, 8'hFF, 8'h00};
    tbl[3] = '{3, 8'h3C, 8'hC3};
    tbl[4] = '{0, 8'h81, 8'h7E};

    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rv", 32'(rsp_valid), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_data", 32'(rsp_data), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      req = '0;
      req[tbl[v].idx] = 1'b1;
      req_data[tbl[v].idx*8 +: 8] = tbl[v].data;
      wait_gnt("tbl_gnt_wait", tg);
      chk("tbl_gnt", 32'(gnt), 32'(1 << tbl[v].idx));
      chk("tbl_busy", 32'(busy), 32'h1);
      req = '0;
      tick();
      chk("tbl_gnt_pulse", 32'(gnt), 32'h0);
      tr = -1;
      for (int i = 0; i < 20 && tr < 0; i++) begin
        if (rsp_valid) tr = cyc;
        else tick();
      end
      if (tr < 0) timeout("tbl_rsp_wait");
      chk("tbl_lat", 32'(tr - tg), 32'd2);
      chk("tbl_id", 32'(rsp_id), 32'(tbl[v].idx));
      chk("tbl_data", 32'(rsp_data), 32'(tbl[v].exp));
      tick();
      chk("tbl_rv_pulse", 32'(rsp_valid), 32'h0);
      chk("tbl_data_hold", 32'(rsp_data), 32'(tbl[v].exp));
      chk("tbl_idle", 32'(busy), 32'h0);
    end

    // Reset mid-BUSY after granting index 2, so ptr was 3 before reset.
    req = 4'b0100;
    req_data[16 +: 8] = 8'h77;
    wait_gnt("mid_gnt_wait", tg);
    req = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_rv", 32'(rsp_valid), 32'h0);
    chk("mid_rst_id", 32'(rsp_id), 32'h0);
    chk("mid_rst_data", 32'(rsp_data), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    nrv = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid) nrv++;
    end
    chk("post_rst_no_rsp", 32'(nrv), 32'h0);

    // All four requesting: grants 0,1,2,3 every LAT+1 cycles.
    exp4 = '{8'hEE, 8'hDD, 8'hBB, 8'h77};
    req_data = {8'h88, 8'h44, 8'h22, 8'h11};
    req = 4'b1111;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("all_gnt_wait", tg);
      chk("all_gnt", 32'(gnt), 32'(1 << k));
      if (k > 0) chk("all_gap", 32'(tg - prev), 32'd3);
      prev = tg;
      req[k] = 1'b0;
      wait_rsp("all_rsp_wait", tr);
      chk("all_id", 32'(rsp_id), 32'(k));
      chk("all_data", 32'(rsp_data), 32'(exp4[k]));
    end
    tick();

    // Fairness: 1 and 3 continuously requesting alternate.
    fair_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    req_data = {8'hF0, 8'h00, 8'h0F, 8'h00};
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("fair_gnt_wait", tg);
      chk("fair_gnt", 32'(gnt), 32'(fair_seq[k]));
      if (k == 3) req = '0;
      wait_rsp("fair_rsp_wait", tr);
      chk("fair_data", 32'(rsp_data), (fair_seq[k] == 4'b0010) ? 32'hF0 : 32'h0F);
    end
    tick();

    // Late arrival: req2 raised while index 0 is in flight.
    req_data = {8'h00, 8'h34, 8'h00, 8'h12};
    req = 4'b0001;
    wait_gnt("late_gnt0_wait", prev);
    chk("late_gnt0", 32'(gnt), 32'h1);
    req = 4'b0100;
    wait_rsp("late_rsp0_wait", tr);
    chk("late_id0", 32'(rsp_id), 32'h0);
    chk("late_data0", 32'(rsp_data), 32'hED);
    wait_gnt("late_gnt2_wait", tg);
    chk("late_gnt2", 32'(gnt), 32'h4);
    chk("late_gap", 32'(tg - prev), 32'd3);
    req = '0;
    wait_rsp("late_rsp2_wait", tr);
    chk("late_id2", 32'(rsp_id), 32'h2);
    chk("late_data2", 32'(rsp_data), 32'hCB);
    tick();
    tick();
    chk("late_idle_busy", 32'(busy), 32'h0);

    // WIDTH=1 build, LAT=1: plain inverter truth table.
    run_w1(0, 1'b0, 1'b1);
    run_w1(1, 1'b1, 1'b0);
    run_w1(0, 1'b1, 1'b0);
    run_w1(1, 1'b0, 1'b1);
    chk("w1_idle_busy", 32'(q_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
